// File: rtl/dp_ram_init_if.sv
// Bus bundle for dp_ram_init: both request ports plus read data, valids and status.
//   master: drives addr/data/we/re for ports A and B, observes q/valid/init_busy/collision
//   slave : the RAM side of the same signals
interface dp_ram_init_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6
);
    logic [DATA_W-1:0] data_a, data_b;
    logic [ADDR_W-1:0] addr_a, addr_b;
    logic              we_a, we_b, re_a, re_b;
    logic [DATA_W-1:0] q_a, q_b;
    logic              valid_a, valid_b;
    logic              init_busy;
    logic              collision;

    modport master (
        output data_a, addr_a, we_a, re_a, data_b, addr_b, we_b, re_b,
        input  q_a, q_b, valid_a, valid_b, init_busy, collision
    );
    modport slave (
        input  data_a, addr_a, we_a, re_a, data_b, addr_b, we_b, re_b,
        output q_a, q_b, valid_a, valid_b, init_busy, collision
    );
endinterface

// File: rtl/dp_ram_init.sv
// True dual-port synchronous RAM with a post-reset clear sequencer.
//   clk       : single clock, rising edge
//   rst_n     : asynchronous active-low reset (restarts the clear sequence)
//   bus       : slave side of dp_ram_init_if (ports A/B requests, q/valid, init_busy, collision)
// Read latency is 1 + OUT_REG. Port A wins simultaneous same-address writes.
module dp_ram_init #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 6,
    parameter int OUT_REG  = 0,
    parameter int RDW_MODE = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    dp_ram_init_if.slave    bus
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {S_INIT, S_READY} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              ready;
    logic              wr_a, wr_b, same_addr;
    logic [DATA_W-1:0] rd_a_d, rd_b_d;

    logic [DATA_W-1:0] q1_a_q, q1_b_q;
    logic              v1_a_q, v1_b_q;
    logic              collision_q;

    // ---------------- clear sequencer ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_INIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == {ADDR_W{1'b1}}) state_d = S_READY;
            end
            S_READY: ;
            default: state_d = S_INIT;
        endcase
    end

    assign ready = (state_q == S_READY);

    // ---------------- array ----------------
    assign same_addr = (bus.addr_a == bus.addr_b);
    assign wr_a      = ready & bus.we_a;
    // B's write is dropped when A writes the same word in the same cycle
    assign wr_b      = ready & bus.we_b & ~(bus.we_a & same_addr);

    // Array is not reset; the sequencer zeroes it instead.
    always_ff @(posedge clk) begin
        if (!ready) begin
            mem[cnt_q] <= '0;
        end else begin
            if (wr_a) mem[bus.addr_a] <= bus.data_a;
            if (wr_b) mem[bus.addr_b] <= bus.data_b;
        end
    end

    // Cross-port reads always see the pre-edge word; only the own port's
    // landing write can bypass, and only in write-first mode.
    assign rd_a_d = (RDW_MODE != 0 && wr_a) ? bus.data_a : mem[bus.addr_a];
    assign rd_b_d = (RDW_MODE != 0 && wr_b) ? bus.data_b : mem[bus.addr_b];

    // ---------------- read stage 1 ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q1_a_q      <= '0;
            q1_b_q      <= '0;
            v1_a_q      <= 1'b0;
            v1_b_q      <= 1'b0;
            collision_q <= 1'b0;
        end else begin
            v1_a_q      <= ready & bus.re_a;
            v1_b_q      <= ready & bus.re_b;
            collision_q <= ready & bus.we_a & bus.we_b & same_addr;
            if (ready & bus.re_a) q1_a_q <= rd_a_d;
            if (ready & bus.re_b) q1_b_q <= rd_b_d;
        end
    end

    // ---------------- optional output register ----------------
    generate
        if (OUT_REG != 0) begin : g_oreg
            logic [DATA_W-1:0] q2_a_q, q2_b_q;
            logic              v2_a_q, v2_b_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    q2_a_q <= '0;
                    q2_b_q <= '0;
                    v2_a_q <= 1'b0;
                    v2_b_q <= 1'b0;
                end else begin
                    v2_a_q <= v1_a_q;
                    v2_b_q <= v1_b_q;
                    // hold q unless the stage-1 slot carries a real read
                    if (v1_a_q) q2_a_q <= q1_a_q;
                    if (v1_b_q) q2_b_q <= q1_b_q;
                end
            end
            assign bus.q_a     = q2_a_q;
            assign bus.q_b     = q2_b_q;
            assign bus.valid_a = v2_a_q;
            assign bus.valid_b = v2_b_q;
        end else begin : g_noreg
            assign bus.q_a     = q1_a_q;
            assign bus.q_b     = q1_b_q;
            assign bus.valid_a = v1_a_q;
            assign bus.valid_b = v1_b_q;
        end
    endgenerate

    assign bus.init_busy = ~ready;
    assign bus.collision = collision_q;

endmodule

// File: tb/tb_dp_ram_init.sv
// Directed bench for dp_ram_init: two instances share one stimulus stream,
// u_dut0 (latency 1, read-first) and u_dut1 (latency 2, write-first).
module tb_dp_ram_init;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    dp_ram_init_if #(.DATA_W(8), .ADDR_W(6)) if0 ();
    dp_ram_init_if #(.DATA_W(8), .ADDR_W(6)) if1 ();

    assign if1.data_a = if0.data_a;
    assign if1.addr_a = if0.addr_a;
    assign if1.we_a   = if0.we_a;
    assign if1.re_a   = if0.re_a;
    assign if1.data_b = if0.data_b;
    assign if1.addr_b = if0.addr_b;
    assign if1.we_b   = if0.we_b;
    assign if1.re_b   = if0.re_b;

    dp_ram_init #(.DATA_W(8), .ADDR_W(6), .OUT_REG(0), .RDW_MODE(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .bus(if0));
    dp_ram_init #(.DATA_W(8), .ADDR_W(6), .OUT_REG(1), .RDW_MODE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .bus(if1));

    // {valid_a, valid_b, collision, init_busy, q_a, q_b}
    logic [19:0] o0, o1;
    assign o0 = {if0.valid_a, if0.valid_b, if0.collision, if0.init_busy, if0.q_a, if0.q_b};
    assign o1 = {if1.valid_a, if1.valid_b, if1.collision, if1.init_busy, if1.q_a, if1.q_b};

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic wa, input logic [5:0] aa, input logic [7:0] da, input logic ra,
                       input logic wb, input logic [5:0] ab, input logic [7:0] db, input logic rb);
        if0.we_a = wa; if0.addr_a = aa; if0.data_a = da; if0.re_a = ra;
        if0.we_b = wb; if0.addr_b = ab; if0.data_b = db; if0.re_b = rb;
    endtask

    task automatic idle;
        drv(1'b0, 6'd0, 8'd0, 1'b0, 1'b0, 6'd0, 8'd0, 1'b0);
    endtask

    // assert reset and check the async-cleared outputs right away
    task automatic rst_pulse(input string tag);
        rst_n = 1'b0;
        #1;
        chk({tag, "_d0"}, {12'd0, o0}, 32'h1_0000);
        chk({tag, "_d1"}, {12'd0, o1}, 32'h1_0000);
    endtask

    // release reset and count rising edges until init_busy drops (bounded)
    task automatic wait_init(output int n);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        while (n < 200) begin
            tick();
            n++;
            if (!if0.init_busy) break;
        end
    endtask

    logic [7:0] m [64];
    logic [7:0] pa, pb, rda1, rdb1;
    logic [7:0] e0qa, e0qb, s1qa, s1qb, o1qa, o1qb;
    logic       e0va, e0vb, s1va, s1vb, o1va, o1vb, col;
    logic       wa, wb, ra, rb;
    logic [5:0] aa, ab;
    int         n;

    initial begin
        idle();
        #2;
        // ---- 1: reset, clear sequence length, all words zero ----
        rst_pulse("t1_rst");
        wait_init(n);
        chk("t1_busy_edges", n, 64);
        chk("t1_busy1", {31'd0, if1.init_busy}, 0);
        for (int k = 0; k <= 64; k++) begin
            if (k < 64) drv(1'b0, 6'(k), 8'd0, 1'b1, 1'b0, 6'(63 - k), 8'd0, 1'b1);
            else idle();
            tick();
            chk("t1_rd_d0", {12'd0, o0}, (k < 64) ? 32'hC_0000 : 32'h0);
            if (k >= 1) chk("t1_rd_d1", {12'd0, o1}, 32'hC_0000);
        end
        idle();
        tick();

        // ---- 3: write A then read B, latency 1 vs 2 ----
        drv(1'b1, 6'd5, 8'h11, 1'b0, 1'b0, 6'd0, 8'd0, 1'b0);
        tick();
        drv(1'b0, 6'd0, 8'd0, 1'b0, 1'b0, 6'd5, 8'd0, 1'b1);
        tick();
        chk("t3_d0_rd", {if0.valid_b, if0.q_b}, 9'h111);
        chk("t3_d1_early", {31'd0, if1.valid_b}, 0);
        idle();
        tick();
        chk("t3_d1_rd", {if1.valid_b, if1.q_b}, 9'h111);
        chk("t3_d0_hold", {if0.valid_b, if0.q_b}, 9'h011);

        // ---- 4: same-address write collision, A wins ----
        drv(1'b1, 6'd9, 8'hAA, 1'b0, 1'b1, 6'd9, 8'h55, 1'b0);
        tick();
        chk("t4_col", {if0.collision, if1.collision}, 2'b11);
        idle();
        tick();
        chk("t4_col_end", {if0.collision, if1.collision}, 2'b00);
        drv(1'b0, 6'd9, 8'd0, 1'b1, 1'b0, 6'd0, 8'd0, 1'b0);
        tick();
        chk("t4_d0_rd", {if0.valid_a, if0.q_a}, 9'h1AA);
        idle();
        tick();
        chk("t4_d1_rd", {if1.valid_a, if1.q_a}, 9'h1AA);

        // ---- 5: read-during-write, same port and cross port ----
        drv(1'b1, 6'd3, 8'h22, 1'b0, 1'b0, 6'd0, 8'd0, 1'b0);
        tick();
        drv(1'b1, 6'd3, 8'h77, 1'b1, 1'b0, 6'd3, 8'd0, 1'b1);
        tick();
        chk("t5_d0_rdw", {if0.q_a, if0.q_b}, 16'h2222);
        idle();
        tick();
        chk("t5_d1_rdw", {if1.q_a, if1.q_b}, 16'h7722);
        drv(1'b0, 6'd0, 8'd0, 1'b0, 1'b0, 6'd3, 8'd0, 1'b1);
        tick();
        chk("t5_d0_after", {if0.valid_b, if0.q_b}, 9'h177);
        idle();
        tick();

        // ---- 2: reset mid-READY, then again mid-INIT ----
        rst_pulse("t2_rdy");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) tick();
        rst_pulse("t2_init");
        wait_init(n);
        chk("t2_busy_edges", n, 64);
        drv(1'b0, 6'd9, 8'd0, 1'b1, 1'b0, 6'd5, 8'd0, 1'b1);
        tick();
        chk("t2_cleared", {if0.valid_a, if0.valid_b, if0.q_a, if0.q_b}, 18'h3_0000);
        idle();
        tick();

        // ---- 6: long mixed traffic against a golden model ----
        rst_pulse("t6_rst");
        wait_init(n);
        chk("t6_busy_edges", n, 64);
        for (int i = 0; i < 64; i++) m[i] = 8'h00;
        e0qa = 0; e0qb = 0; s1qa = 0; s1qb = 0; o1qa = 0; o1qb = 0;
        e0va = 0; e0vb = 0; s1va = 0; s1vb = 0; o1va = 0; o1vb = 0;
        pa = 0; pb = 0;
        for (int c = 0; c < 10000; c++) begin
            wa = (c % 2 == 0);
            ra = (c % 2 == 1) || (c % 7 == 0);
            wb = (c % 3 != 0);
            rb = (c % 2 == 0) || (c % 5 == 0);
            aa = pa[5:0];
            ab = pb[5:0];
            drv(wa, aa, pa, ra, wb, ab, pb ^ 8'h5A, rb);
            col  = wa & wb & (aa == ab);
            rda1 = wa ? pa : m[aa];
            rdb1 = (wb && !col) ? (pb ^ 8'h5A) : m[ab];
            // latency-1, read-first instance
            if (ra) e0qa = m[aa];
            if (rb) e0qb = m[ab];
            e0va = ra;
            e0vb = rb;
            // latency-2, write-first instance
            o1va = s1va; if (s1va) o1qa = s1qa;
            o1vb = s1vb; if (s1vb) o1qb = s1qb;
            s1va = ra;   if (ra) s1qa = rda1;
            s1vb = rb;   if (rb) s1qb = rdb1;
            // array update, A overrides B
            if (wb) m[ab] = pb ^ 8'h5A;
            if (wa) m[aa] = pa;
            tick();
            chk("t6_d0", {12'd0, o0}, {12'd0, e0va, e0vb, col, 1'b0, e0qa, e0qb});
            chk("t6_d1", {12'd0, o1}, {12'd0, o1va, o1vb, col, 1'b0, o1qa, o1qb});
            pa = pa + 8'd17;
            pb = pb + 8'd5;
        end
        idle();
        tick();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
